// File: rtl/dffram_arb_pkg.sv
// Shared constants and FSM state type for the DFFRAM512x32 arbiter.
// The RAM geometry is fixed by the macro: 512 words of 32 bits, in 4 byte lanes.
package dffram_arb_pkg;
  localparam int A_WIDTH    = 9;
  localparam int D_WIDTH    = 32;
  localparam int NUM_WORDS  = 512;
  localparam int BYTE_LANES = 4;
  // One extra bit so the clear counter can never silently wrap back into a new clear.
  localparam int CNT_W      = A_WIDTH + 1;

  typedef enum logic {
    ST_ARB,
    ST_CLEAR
  } arb_state_e;
endpackage

// File: rtl/dffram_arbiter_if.sv
// Requester and RAM-macro signals of the arbiter, bundled as one bus.
// The slave modport is the arbiter's view; the master modport is the view of requesters and the macro.
interface dffram_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import dffram_arb_pkg::*;

  // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
  // req_ready is combinational from req_valid, so valid must never wait on ready.
  // rsp_valid[i] strobes for exactly one cycle after that transfer and qualifies rsp_rdata.
  logic                         clr_start;
  logic                         clr_busy;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*BYTE_LANES-1:0] req_we;
  logic [NUM_REQ*A_WIDTH-1:0]   req_addr;
  logic [NUM_REQ*D_WIDTH-1:0]   req_wdata;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [D_WIDTH-1:0]           rsp_rdata;
  logic                         ram_en;
  logic [BYTE_LANES-1:0]        ram_we;
  logic [A_WIDTH-1:0]           ram_addr;
  logic [D_WIDTH-1:0]           ram_di;
  logic [D_WIDTH-1:0]           ram_do;
  arb_state_e                   dbg_state;

  modport slave (
    input  clr_start, req_valid, req_we, req_addr, req_wdata, ram_do,
    output clr_busy, req_ready, rsp_valid, rsp_rdata,
           ram_en, ram_we, ram_addr, ram_di, dbg_state
  );

  modport master (
    output clr_start, req_valid, req_we, req_addr, req_wdata, ram_do,
    input  clr_busy, req_ready, rsp_valid, rsp_rdata,
           ram_en, ram_we, ram_addr, ram_di, dbg_state
  );
endinterface

// File: rtl/dffram_arbiter_rr.sv
// Round-robin grant selection: searches ptr+1, ptr+2, ... modulo NUM_REQ for the first active request.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o
);
  always_comb begin
    int  idx;
    logic found;
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    found         = 1'b0;
    idx           = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        grant_valid_o = 1'b1;
        grant_o[idx]  = 1'b1;
        grant_idx_o   = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/dffram_arbiter.sv
// Shares one single-port DFFRAM512x32 between NUM_REQ requesters (round-robin) and
// runs a bulk-clear sequence that writes zero to all 512 words on command.
module dffram_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic           CLK,
  input  logic           RST,
  dffram_arbiter_if.slave bus
);
  import dffram_arb_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               grant_en;
  logic               grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i         (bus.req_valid),
    .ptr_i         (rr_ptr_q),
    .grant_o       (gnt_onehot),
    .grant_idx_o   (gnt_idx),
    .grant_valid_o (gnt_any)
  );

  // A clear command steals its own cycle: nobody is granted while it is being accepted.
  assign grant_en = !RST && (state_q == ST_ARB) && !bus.clr_start;
  assign grant    = grant_en && gnt_any;

  assign bus.req_ready = grant_en ? gnt_onehot : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = bus.ram_do;
  assign bus.clr_busy  = (state_q == ST_CLEAR);
  assign bus.dbg_state = state_q;

  always_comb begin
    bus.ram_en   = 1'b0;
    bus.ram_we   = '0;
    bus.ram_addr = '0;
    bus.ram_di   = '0;
    if (!RST) begin
      if (state_q == ST_CLEAR) begin
        bus.ram_en   = 1'b1;
        bus.ram_we   = '1;
        bus.ram_addr = clr_cnt_q[A_WIDTH-1:0];
      end else if (grant) begin
        bus.ram_en   = 1'b1;
        bus.ram_we   = bus.req_we[gnt_idx*BYTE_LANES +: BYTE_LANES];
        bus.ram_addr = bus.req_addr[gnt_idx*A_WIDTH +: A_WIDTH];
        bus.ram_di   = bus.req_wdata[gnt_idx*D_WIDTH +: D_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    unique case (state_q)
      ST_ARB: begin
        if (bus.clr_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (gnt_any) begin
          rr_ptr_d    = gnt_idx;
          rsp_valid_d = gnt_onehot;
        end
      end
      ST_CLEAR: begin
        // clr_start is not looked at here, so a second pulse cannot restart or extend the sweep.
        if (clr_cnt_q == CNT_W'(NUM_WORDS - 1)) begin
          state_d   = ST_ARB;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_ARB;
      clr_cnt_q   <= '0;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter with a behavioural read-before-write DFFRAM512x32 behind it.
module tb_dffram_arbiter;
  import dffram_arb_pkg::*;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:511];

  dffram_arbiter_if #(.NUM_REQ(2)) bus ();

  dffram_arbiter #(.NUM_REQ(2)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Macro model: registered read of the old word, byte-lane writes.
  always @(posedge CLK) begin
    if (bus.ram_en) begin
      bus.ram_do <= mem[bus.ram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_di[8*b +: 8];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    RST = 1'b1;
    bus.req_valid = 2'b11;
    repeat (cycles) @(posedge CLK);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_ram_en", 32'(bus.ram_en), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    bus.req_valid = '0;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_clr_busy", 32'(bus.clr_busy), 32'h0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_ARB));
  endtask

  task automatic set_req(input int r, input logic [3:0] we, input logic [8:0] addr,
                         input logic [31:0] wd);
    bus.req_we[r*4 +: 4]    = we;
    bus.req_addr[r*9 +: 9]  = addr;
    bus.req_wdata[r*32 +: 32] = wd;
  endtask

  // One request from requester r; when chk is set the response word is scoreboarded.
  task automatic do_req(input int r, input logic [3:0] we, input logic [8:0] addr,
                        input logic [31:0] wd, input bit chk, input logic [31:0] exp);
    int waited;
    logic [1:0] onehot;
    waited = 0;
    onehot = 2'b01 << r;
    @(negedge CLK);
    set_req(r, we, addr, wd);
    bus.req_valid = onehot;
    #1;
    while (!bus.req_ready[r] && waited < 20) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    check("req_ready", 32'(bus.req_ready), 32'(onehot));
    if (chk) exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    bus.req_valid = '0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(onehot));
    if (chk) check("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
  endtask

  // Pulses clr_start and follows the sweep until clr_busy drops (bounded).
  task automatic run_clear(input int restart_at, input int rst_at,
                           output int cycles, output int viol);
    cycles = 0;
    viol   = 0;
    @(negedge CLK);
    bus.clr_start = 1'b1;
    #1;
    if (bus.req_ready !== 2'b00) viol++;
    @(posedge CLK);
    #1;
    bus.clr_start = 1'b0;
    while (bus.clr_busy && cycles < 600) begin
      if (bus.req_ready !== 2'b00 || bus.ram_en !== 1'b1 || bus.ram_we !== 4'hF ||
          bus.ram_di !== 32'h0 || bus.ram_addr !== 9'(cycles)) viol++;
      if (cycles == rst_at) begin
        RST = 1'b1;
        #1;
        if (bus.ram_en !== 1'b0 || bus.req_ready !== 2'b00) viol++;
      end
      if (cycles == restart_at) bus.clr_start = 1'b1;
      cycles++;
      @(posedge CLK);
      #1;
      bus.clr_start = 1'b0;
      RST = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int viol;
    n_checks      = 0;
    n_errors      = 0;
    RST           = 1'b1;
    bus.clr_start = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // 1: reset, write then read back
    do_reset(3);
    do_req(0, 4'hF, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0);
    do_req(0, 4'h0, 9'h010, 32'h0, 1'b1, 32'hDEADBEEF);
    @(posedge CLK);
    #1;
    check("rsp_strobe_drop", 32'(bus.rsp_valid), 32'h0);

    // 2: two contending readers alternate, req0 first after reset
    do_req(0, 4'hF, 9'h020, 32'hA5A50020, 1'b0, 32'h0);
    do_req(1, 4'hF, 9'h021, 32'h5A5A0021, 1'b0, 32'h0);
    do_reset(2);
    @(negedge CLK);
    set_req(0, 4'h0, 9'h020, 32'h0);
    set_req(1, 4'h0, 9'h021, 32'h0);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("alt_ready", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      @(posedge CLK);
      #1;
      check("alt_rsp_valid", 32'(bus.rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("alt_rdata", bus.rsp_rdata, (k % 2 == 0) ? 32'hA5A50020 : 32'h5A5A0021);
      @(negedge CLK);
    end
    bus.req_valid = '0;

    // 3: byte lanes 0 and 2 overwritten; write ack carries the pre-write word
    do_req(0, 4'hF, 9'h030, 32'h11223344, 1'b0, 32'h0);
    do_req(1, 4'b0101, 9'h030, 32'hAABBCCDD, 1'b1, 32'h11223344);
    do_req(0, 4'h0, 9'h030, 32'h0, 1'b1, 32'h11BB33DD);

    // 4: full clear with a reader waiting the whole time
    do_req(0, 4'hF, 9'h000, 32'h00000001, 1'b0, 32'h0);
    do_req(1, 4'hF, 9'h0FF, 32'h00000002, 1'b0, 32'h0);
    do_req(0, 4'hF, 9'h1FF, 32'h00000003, 1'b0, 32'h0);
    @(negedge CLK);
    set_req(0, 4'h0, 9'h000, 32'h0);
    bus.req_valid = 2'b01;
    run_clear(-1, -1, cyc, viol);
    check("clr_len", 32'(cyc), 32'd512);
    check("clr_bus", 32'(viol), 32'd0);
    check("post_clr_ready", 32'(bus.req_ready), 32'h1);
    @(posedge CLK);
    #1;
    bus.req_valid = '0;
    check("post_clr_rsp", 32'(bus.rsp_valid), 32'h1);
    check("clr_word0", bus.rsp_rdata, 32'h0);
    do_req(1, 4'h0, 9'h0FF, 32'h0, 1'b1, 32'h0);
    do_req(0, 4'h0, 9'h1FF, 32'h0, 1'b1, 32'h0);

    // 5: req1 collides with clr_start, second pulse mid-clear is ignored
    @(negedge CLK);
    set_req(1, 4'h0, 9'h0FF, 32'h0);
    bus.req_valid = 2'b10;
    run_clear(50, -1, cyc, viol);
    check("clr_restart_len", 32'(cyc), 32'd512);
    check("clr_restart_bus", 32'(viol), 32'd0);
    check("req1_after_clr", 32'(bus.req_ready), 32'h2);
    @(posedge CLK);
    #1;
    bus.req_valid = '0;
    check("req1_rsp", 32'(bus.rsp_valid), 32'h2);
    check("req1_rdata", bus.rsp_rdata, 32'h0);

    // 6: reset aborts a clear at cycle 100, then a fresh clear runs to completion
    do_req(0, 4'hF, 9'h055, 32'h12345678, 1'b0, 32'h0);
    run_clear(-1, 100, cyc, viol);
    check("abort_len", 32'(cyc), 32'd101);
    check("abort_bus", 32'(viol), 32'd0);
    check("abort_state", 32'(bus.dbg_state), 32'(ST_ARB));
    check("abort_busy", 32'(bus.clr_busy), 32'h0);
    run_clear(-1, -1, cyc, viol);
    check("reclr_len", 32'(cyc), 32'd512);
    check("reclr_bus", 32'(viol), 32'd0);
    do_req(0, 4'h0, 9'h055, 32'h0, 1'b1, 32'h0);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
